// File: rtl/frame_buffer_reader.sv
// Frame buffer reader: scans a 2-cycle-latency BRAM port from address 0 to RAM_DEPTH-1
// and streams the words out on a valid/ready interface through a small credit-managed
// output FIFO, so no word is lost regardless of downstream back-pressure.
// Optional feature: define FBR_LOOP_EN to scan frames back to back until reset.
module frame_buffer_reader #(
  parameter int unsigned RAM_WIDTH = 18,
  parameter int unsigned RAM_DEPTH = 1024,
  parameter int unsigned BUF_DEPTH = 4,
  localparam int unsigned AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                 clka,
  input  logic                 rstb,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [AW-1:0]        bram_addr_o,
  output logic                 bram_en_o,
  output logic                 bram_regce_o,
  input  logic [RAM_WIDTH-1:0] bram_dout_i,
  output logic [RAM_WIDTH-1:0] m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic                 m_last_o
);

  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
  localparam logic [AW-1:0]   LastAddr  = AW'(RAM_DEPTH - 1);
  localparam logic [PtrW-1:0] LastPtr   = PtrW'(BUF_DEPTH - 1);
  localparam logic [CntW:0]   BufDepthW = (CntW + 1)'(BUF_DEPTH);

  typedef enum logic [1:0] {StIdle, StScan, StDrain} state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  done_q, done_d;
  logic                  regce_q;
  logic [1:0]            inflight_q;
  logic [1:0]            inflight_last_q;
  logic [RAM_WIDTH-1:0]  buf_data_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]  buf_last_q;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;

  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  m_valid;
  logic                  head_last;
  logic [CntW:0]         pending;
  logic                  has_room;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // A word is pushed exactly when its read leaves the second in-flight stage.
  assign push      = inflight_q[1];
  assign m_valid   = (count_q != '0);
  assign pop       = m_valid & m_ready_i;
  assign head_last = buf_last_q[rd_ptr_q];

  // Credit check: words buffered plus reads still in the BRAM pipe must fit the FIFO.
  always_comb begin
    pending  = {1'b0, count_q}
             + {{CntW{1'b0}}, inflight_q[0]}
             + {{CntW{1'b0}}, inflight_q[1]};
    has_room = (pending < BufDepthW);
  end

  // Next-state, address sequencing and read issue.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StScan;
      end
      StScan: begin
        if (has_room) begin
          issue = 1'b1;
          if (addr_q == LastAddr) begin
            addr_d = '0;
`ifdef FBR_LOOP_EN
            state_d = StScan;
`else
            state_d = StDrain;
`endif
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (pop && head_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state register.
  always_ff @(posedge clka) begin
    if (rstb) begin
      state_q <= StIdle;
      addr_q  <= '0;
      done_q  <= 1'b0;
      regce_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      regce_q <= 1'b1;
    end
  end

  // Two-stage tracker of reads in the BRAM pipeline, with the frame-end tag riding along.
  always_ff @(posedge clka) begin
    if (rstb) begin
      inflight_q      <= '0;
      inflight_last_q <= '0;
    end else begin
      inflight_q      <= {inflight_q[0], issue};
      inflight_last_q <= {inflight_last_q[0], issue && (addr_q == LastAddr)};
    end
  end

  // Output FIFO; reset also discards anything still returning from aborted reads.
  always_ff @(posedge clka) begin
    if (rstb) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) buf_data_q[i] <= '0;
      buf_last_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (push) begin
        buf_data_q[wr_ptr_q] <= bram_dout_i;
        buf_last_q[wr_ptr_q] <= inflight_last_q[1];
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign busy_o       = (state_q != StIdle);
  assign done_o       = done_q;
  assign bram_addr_o  = addr_q;
  assign bram_en_o    = issue;
  assign bram_regce_o = regce_q;
  assign m_data_o     = buf_data_q[rd_ptr_q];
  assign m_valid_o    = m_valid;
  assign m_last_o     = m_valid & head_last;

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Scoreboard bench for frame_buffer_reader with a 16-word BRAM model holding data = address.
module tb_frame_buffer_reader;

  localparam int unsigned W  = 18;
  localparam int unsigned D  = 16;
  localparam int unsigned B  = 4;
  localparam int unsigned AW = 4;

  logic          clka = 1'b0;
  logic          rstb = 1'b1;
  logic          start = 1'b0;
  logic          busy, done;
  logic [AW-1:0] bram_addr;
  logic          bram_en, bram_regce;
  logic [W-1:0]  bram_dout;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } exp_t;
  exp_t sb[$];

  frame_buffer_reader #(
    .RAM_WIDTH (W),
    .RAM_DEPTH (D),
    .BUF_DEPTH (B)
  ) dut (
    .clka         (clka),
    .rstb         (rstb),
    .start_i      (start),
    .busy_o       (busy),
    .done_o       (done),
    .bram_addr_o  (bram_addr),
    .bram_en_o    (bram_en),
    .bram_regce_o (bram_regce),
    .bram_dout_i  (bram_dout),
    .m_data_o     (m_data),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .m_last_o     (m_last)
  );

  always #5 clka = ~clka;

  // BRAM model: array stage then output register, 2-cycle latency, not cleared by reset.
  logic [W-1:0] bram_p1 = '0;
  initial bram_dout = '0;
  always @(posedge clka) begin
    if (bram_en) bram_p1 <= W'(bram_addr);
    if (bram_regce) bram_dout <= bram_p1;
  end

  // Independent occupancy model: a read lands in the buffer two cycles after bram_en.
  logic en_d1 = 1'b0, en_d2 = 1'b0;
  int   occ   = 0;
  always @(posedge clka) begin
    if (rstb) begin
      en_d1 <= 1'b0;
      en_d2 <= 1'b0;
      occ   <= 0;
    end else begin
      en_d1 <= bram_en;
      en_d2 <= en_d1;
      occ   <= occ + int'(en_d2) - int'(m_valid && m_ready);
    end
  end

  // Monitor: pops and compares every handshake, counts done pulses, checks read credit.
  always @(negedge clka) begin
    exp_t e;
    if (!rstb && m_valid && m_ready) begin
      xfers++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow actual data=%0d last=%0b required=no transfer", m_data, m_last);
      end else begin
        e = sb.pop_front();
        if (m_data !== e.d || m_last !== e.l) begin
          failures++;
          $display("FAIL sb_word actual data=%0d last=%0b required data=%0d last=%0b",
                   m_data, m_last, e.d, e.l);
        end
      end
    end
    if (done) done_cnt++;
    if (!rstb && bram_en) begin
      checks++;
      if (occ + int'(en_d1) + int'(en_d2) >= int'(B)) begin
        failures++;
        $display("FAIL credit actual pending=%0d required <%0d", occ + int'(en_d1) + int'(en_d2), B);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push_frames(input int n);
    for (int f = 0; f < n; f++)
      for (int i = 0; i < int'(D); i++) sb.push_back({W'(i), (i == int'(D) - 1)});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clka); #1;
    start = 1'b0;
  endtask

  task automatic wait_xfers(input int target);
    int n = 0;
    while (xfers < target && n < 300) begin
      @(posedge clka); #1;
      n++;
    end
    if (xfers < target) chk("wait_xfers_timeout", xfers, target);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 400) begin
      @(posedge clka); #1;
      n++;
    end
    chk("done_seen", {31'd0, done}, 1);
  endtask

  initial begin
    int n, base, dc;
    repeat (3) @(posedge clka);
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_en", {31'd0, bram_en}, 0);
    chk("rst_regce", {31'd0, bram_regce}, 0);
    chk("rst_addr", {28'd0, bram_addr}, 0);
    chk("rst_valid", {31'd0, m_valid}, 0);
    chk("rst_last", {31'd0, m_last}, 0);
    chk("rst_data", {14'd0, m_data}, 0);
    rstb = 1'b0;
    @(posedge clka); #1;
    chk("regce_after_rst", {31'd0, bram_regce}, 1);

`ifdef FBR_LOOP_EN
    m_ready = 1'b1;
    push_frames(3);
    pulse_start();
    n = 0;
    while (!m_valid && n < 20) begin
      @(posedge clka); #1;
      n++;
    end
    chk("loop_first_valid", n, 3);
    base = xfers;
    dc   = done_cnt;
    repeat (40) begin
      @(posedge clka); #1;
    end
    chk("loop_xfers", xfers - base, 40);
    chk("loop_no_done", done_cnt - dc, 0);
    chk("loop_busy", {31'd0, busy}, 1);
    rstb = 1'b1;
    @(posedge clka); #1;
    rstb = 1'b0;
    chk("loop_rst_valid", {31'd0, m_valid}, 0);
    sb.delete();
`else
    // Basic frame, ready held high.
    m_ready = 1'b1;
    push_frames(1);
    pulse_start();
    chk("busy_rise", {31'd0, busy}, 1);
    n = 0;
    while (!m_valid && n < 20) begin
      @(posedge clka); #1;
      n++;
    end
    chk("first_valid_latency", n, 3);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clka); #1;
      n++;
    end
    chk("stream_cycles_to_done", n, 16);
    chk("busy_fall_with_done", {31'd0, busy}, 0);
    @(posedge clka); #1;
    chk("done_single_cycle", {31'd0, done}, 0);
    chk("done_count_a", done_cnt, 1);
    chk("sb_empty_a", sb.size(), 0);

    // Stall mid-frame for 10 cycles.
    base = xfers;
    dc   = done_cnt;
    push_frames(1);
    pulse_start();
    wait_xfers(base + 5);
    m_ready = 1'b0;
    repeat (10) begin
      @(posedge clka); #1;
    end
    chk("stall_en_low", {31'd0, bram_en}, 0);
    chk("stall_pending", occ + int'(en_d1) + int'(en_d2), 4);
    m_ready = 1'b1;
    wait_done();
    @(posedge clka); #1;
    chk("stall_xfers", xfers - base, 16);
    chk("stall_done_count", done_cnt - dc, 1);
    chk("sb_empty_b", sb.size(), 0);

    // Random back-pressure.
    base = xfers;
    dc   = done_cnt;
    push_frames(1);
    pulse_start();
    n = 0;
    while (!done && n < 400) begin
      @(posedge clka); #1;
      m_ready = 1'($urandom_range(0, 1));
      n++;
    end
    chk("rand_done_seen", {31'd0, done}, 1);
    m_ready = 1'b1;
    @(posedge clka); #1;
    chk("rand_xfers", xfers - base, 16);
    chk("rand_done_count", done_cnt - dc, 1);
    chk("sb_empty_c", sb.size(), 0);

    // Second start while busy must be ignored.
    base = xfers;
    dc   = done_cnt;
    push_frames(1);
    pulse_start();
    wait_xfers(base + 5);
    pulse_start();
    wait_done();
    @(posedge clka); #1;
    chk("restart_xfers", xfers - base, 16);
    chk("restart_done_count", done_cnt - dc, 1);
    repeat (5) begin
      @(posedge clka); #1;
    end
    chk("restart_idle", {31'd0, busy}, 0);
    chk("sb_empty_d", sb.size(), 0);

    // Reset mid-frame aborts; stale returning data must not appear.
    push_frames(1);
    pulse_start();
    wait_xfers(xfers + 7);
    rstb = 1'b1;
    @(posedge clka); #1;
    chk("abort_valid", {31'd0, m_valid}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    rstb = 1'b0;
    sb.delete();
    repeat (4) begin
      @(posedge clka); #1;
    end
    chk("abort_no_stale", {31'd0, m_valid}, 0);
    base = xfers;
    dc   = done_cnt;
    push_frames(1);
    pulse_start();
    wait_done();
    @(posedge clka); #1;
    chk("post_abort_xfers", xfers - base, 16);
    chk("post_abort_done", done_cnt - dc, 1);
    chk("sb_empty_e", sb.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_buffer_reader.md
FRAME_BUFFER_READER -- requirements
Module: frame_buffer_reader

Interface
REQ-001 Parameter RAM_WIDTH, default 18, pixel/word width in bits.
REQ-002 Parameter RAM_DEPTH, default 1024, words per frame; AW = ceil(log2(RAM_DEPTH)).
REQ-003 Parameter BUF_DEPTH, default 4, output buffer entries, minimum 3.
REQ-004 clka  in  1  sole clock, rising edge.
REQ-005 rstb  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  single-cycle frame scan request.
REQ-007 busy  out  1  high from accepted start until last word leaves m_data.
REQ-008 done  out  1  one-cycle pulse the cycle after the last word handshakes.
REQ-009 bram_addr  out  AW  read address to 2-cycle-latency BRAM port.
REQ-010 bram_en  out  1  read issue strobe, one word per high cycle.
REQ-011 bram_regce  out  1  BRAM output register enable.
REQ-012 bram_dout  in  RAM_WIDTH  BRAM read data, valid exactly 2 cycles after bram_en.
REQ-013 m_data  out  RAM_WIDTH  output pixel word.
REQ-014 m_valid  out  1  m_data valid.
REQ-015 m_ready  in  1  downstream accepts; transfer when m_valid & m_ready.
REQ-016 m_last  out  1  high with the word read from address RAM_DEPTH-1.

Function
REQ-017 States IDLE, SCAN, DRAIN; IDLE->SCAN on start; SCAN->DRAIN after address RAM_DEPTH-1 issued; DRAIN->IDLE on last-word handshake.
REQ-018 start while busy SHALL be ignored.
REQ-019 SCAN issues addresses 0,1,...,RAM_DEPTH-1 in order, incrementing only on bram_en cycles.
REQ-020 bram_en SHALL assert only when (buffer occupancy + reads in flight) < BUF_DEPTH.
REQ-021 In-flight reads tracked by 2-stage valid shift register; bram_dout captured into buffer exactly 2 cycles after its bram_en.
REQ-022 bram_regce SHALL be 1 at all times outside reset.
REQ-023 Output buffer FIFO-ordered; no word dropped or duplicated under any m_ready pattern.
REQ-024 Simultaneous buffer push and pop SHALL leave occupancy unchanged.
REQ-025 m_valid = buffer non-empty; m_data/m_last from head entry, stable while m_valid & !m_ready.
REQ-026 With m_ready held high, throughput 1 word/cycle; first m_valid 3 cycles after start.
REQ-027 busy rises the cycle after accepted start; done and busy-fall coincide, 1 cycle after final handshake.

Reset
REQ-028 On rstb: state IDLE, address 0, buffer and in-flight tracker emptied.
REQ-029 Reset values: busy 0, done 0, bram_en 0, bram_regce 0, bram_addr 0, m_valid 0, m_last 0, m_data 0.
REQ-030 rstb mid-scan SHALL abort; data returning from pre-reset reads discarded.

Configuration
REQ-031 Macro FBR_LOOP_EN defined: after address RAM_DEPTH-1, address wraps to 0 and scanning continues indefinitely; DRAIN unused; done never pulses; m_last marks each frame end; only rstb stops.
REQ-032 FBR_LOOP_EN undefined: single frame per start per REQ-017..027.

Verification
REQ-033 RAM_DEPTH=16, BRAM model holds data=addr, m_ready=1, start pulse -> m_data 0..15 on consecutive cycles, m_last on 15, done 1 cycle later.
REQ-034 m_ready low for 10 cycles mid-frame -> bram_en stalls with occupancy+in-flight=4, no loss, sequence resumes intact.
REQ-035 m_ready random 50% -> exactly 16 transfers, in order, one done pulse.
REQ-036 start pulsed again at word 5 -> ignored, single frame output.
REQ-037 rstb asserted at word 7 -> next cycle m_valid=0, busy=0; new start gives 0..15 with no stale words.
REQ-038 FBR_LOOP_EN defined, 40 cycles m_ready=1 -> data 0..15,0..15,0..7, m_last at 15 twice, no done.
